host_command_decoder: RTL
=========================

Name: host_command_decoder

Overview:
Parses 4-byte write frames arriving from the host UART receiver and converts them into single-cycle register write strobes plus data for the oscilloscope's control registers, such as the 8-bit control register. It sits between the UART RX byte stream and the register bank. It also returns a one-byte ACK/NAK to the UART TX path for every completed frame. Malformed, stalled or out-of-range frames are rejected without touching any register.

Parameters:
NUM_REGS, 4, number of addressable 8-bit registers; valid addresses are 0..NUM_REGS-1 (1..256)
TIMEOUT_CYCLES, 100000, maximum clk cycles allowed between consecutive bytes of one frame
SYNC_BYTE, 8'hA5, frame start marker
ACK_BYTE, 8'h06, response for an accepted frame
NAK_BYTE, 8'h15, response for a rejected frame

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle pulse; rx_data is valid this cycle
rx_data  in  8  received byte
tx_ready  in  1  UART TX can accept a byte
tx_valid  out  1  response byte pending
tx_data  out  8  response byte (ACK_BYTE or NAK_BYTE)
write  out  NUM_REGS  one-hot write strobe, one bit per register, one cycle wide
write_register  out  8  data for the strobed register; held until the next accepted write
frame_error  out  1  one-cycle pulse on any rejected or timed-out frame
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset has priority over every other input; an in-flight frame or pending response is discarded.
- Frame format: SYNC_BYTE, ADDR, DATA, CSUM, where CSUM = (ADDR + DATA) mod 256.
- States: IDLE, ADDR, DATA, CSUM, RESP.
- IDLE:
  - rx_valid with rx_data == SYNC_BYTE -> ADDR.
  - Any other byte is ignored silently, with no error.
- ADDR: rx_valid latches the address -> DATA. A byte equal to SYNC_BYTE is treated as an address; there is no resync.
- DATA: rx_valid latches the data -> CSUM.
- CSUM: rx_valid evaluates the frame -> RESP.
  - Accept only if the checksum matches and ADDR < NUM_REGS.
- Timing for a frame whose checksum byte arrives in cycle N, all results in cycle N+1:
  - On accept: write[ADDR] = 1 for exactly one cycle, write_register = DATA, tx_valid = 1, tx_data = ACK_BYTE.
  - On reject: write stays 0, write_register is unchanged, frame_error = 1 for one cycle, tx_valid = 1, tx_data = NAK_BYTE.
- RESP:
  - tx_valid and tx_data are held stable until tx_valid && tx_ready.
  - In that handshake cycle tx_valid drops on the next edge and the state returns to IDLE.
  - tx_ready already high on entry -> RESP lasts exactly one cycle.
  - rx bytes arriving in RESP are dropped, with no error.
- Timeout:
  - The counter clears on every accepted rx byte and on entering ADDR.
  - It increments each cycle in ADDR, DATA and CSUM.
  - When it reaches TIMEOUT_CYCLES without a byte: return to IDLE, frame_error pulses for one cycle, no response is sent, no write occurs.
  - If rx_valid arrives in the same cycle the counter reaches the limit, the byte wins and no timeout occurs.
  - The counter is inactive in IDLE and RESP.
- Widths:
  - Checksum is computed in 8 bits; the carry is discarded.
  - The address comparison uses the full 8-bit ADDR.
  - The timeout counter is clog2(TIMEOUT_CYCLES+1) bits.
- Ordering: at most one write bit is ever high; write and frame_error are never high together.

Test Plan:
1. Reset, then send A5 02 3C 3E with tx_ready=1 -> cycle after the 3E byte: write=4'b0100, write_register=8'h3C, tx_data=06. busy falls one cycle later.
2. Send A5 01 10 12 (bad checksum) -> frame_error pulses for 1 cycle, tx_data=15, write stays 0, write_register keeps its previous value 8'h3C.
3. Send A5 07 01 08 with NUM_REGS=4 -> NAK 15, frame_error, no write. Then send A5 03 FF 02 (carry wrap) -> write=4'b1000, write_register=FF, ACK.
4. Send 00 FF then A5 00 81 81 -> leading bytes are ignored; write=4'b0001, data 81, ACK, no frame_error.
5. With TIMEOUT_CYCLES=16: send A5 01 then stall 16 cycles -> frame_error pulses, back in IDLE, no tx. A byte arriving on cycle 16 instead is accepted.
6. Hold tx_ready=0 for 10 cycles after a good frame, sending extra bytes meanwhile -> tx_valid=1 and tx_data=06 stay stable and the extra bytes are dropped; release tx_ready -> IDLE. Separately, assert reset during the DATA state -> all outputs 0, no write.

Source files
------------

// File: rtl/host_command_decoder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// host_command_decoder_if: UART byte stream in, response byte and register-write strobes out
// Rev 1.0
// ---------------------------------------------------------------------------
interface host_command_decoder_if #(
  parameter int NUM_REGS = 4
);
  logic                rx_valid;
  logic [7:0]          rx_data;
  logic                tx_ready;
  logic                tx_valid;
  logic [7:0]          tx_data;
  logic [NUM_REGS-1:0] write;
  logic [7:0]          write_register;
  logic                frame_error;
  logic                busy;

  modport master (
    output rx_valid, rx_data, tx_ready,
    input  tx_valid, tx_data, write, write_register, frame_error, busy
  );

  modport slave (
    input  rx_valid, rx_data, tx_ready,
    output tx_valid, tx_data, write, write_register, frame_error, busy
  );
endinterface
`default_nettype wire

// File: rtl/host_command_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// host_command_decoder: parses SYNC/ADDR/DATA/CSUM frames into one-hot register writes plus ACK/NAK
// Rev 1.0
// ---------------------------------------------------------------------------
module host_command_decoder #(
  parameter int         NUM_REGS       = 4,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter logic [7:0] ACK_BYTE       = 8'h06,
  parameter logic [7:0] NAK_BYTE       = 8'h15
) (
  input  logic                  clk,
  input  logic                  reset,
  host_command_decoder_if.slave bus
);

  localparam int                 CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   C_TIMEOUT  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [8:0]         C_NUM_REGS = 9'(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_RESP = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic [NUM_REGS-1:0] write_q, write_d;
  logic [7:0]          wreg_q, wreg_d;
  logic                tx_valid_q, tx_valid_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                ferr_q, ferr_d;

  logic [7:0]          w_csum;
  logic                w_addr_ok;
  logic                w_waiting;
  logic                w_timeout;

  assign w_csum    = addr_q + data_q;
  assign w_addr_ok = ({1'b0, addr_q} < C_NUM_REGS);
  assign w_waiting = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_CSUM);
  // A byte landing in the same cycle the limit is reached still counts.
  assign w_timeout = w_waiting && !bus.rx_valid && (cnt_q == C_TIMEOUT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    write_d    = '0;
    wreg_d     = wreg_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    ferr_d     = 1'b0;

    if (w_waiting) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
          state_d = S_ADDR;
          cnt_d   = '0;
        end
      end
      S_ADDR: begin
        if (bus.rx_valid) begin
          addr_d  = bus.rx_data;
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.rx_valid) begin
          data_d  = bus.rx_data;
          cnt_d   = '0;
          state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (bus.rx_valid) begin
          cnt_d      = '0;
          state_d    = S_RESP;
          tx_valid_d = 1'b1;
          if ((bus.rx_data == w_csum) && w_addr_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              write_d[i] = (addr_q == i[7:0]);
            end
            wreg_d    = data_q;
            tx_data_d = ACK_BYTE;
          end else begin
            ferr_d    = 1'b1;
            tx_data_d = NAK_BYTE;
          end
        end
      end
      S_RESP: begin
        if (tx_valid_q && bus.tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_timeout) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ferr_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      write_q    <= '0;
      wreg_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      write_q    <= write_d;
      wreg_q     <= wreg_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      ferr_q     <= ferr_d;
    end
  end

  assign bus.tx_valid       = tx_valid_q;
  assign bus.tx_data        = tx_data_q;
  assign bus.write          = write_q;
  assign bus.write_register = wreg_q;
  assign bus.frame_error    = ferr_q;
  assign bus.busy           = (state_q != S_IDLE);

endmodule
`default_nettype wire
